// File: rtl/score_counter_if.sv
// score_counter_if: event inputs and BCD display outputs of score_counter.
// master drives count_up/count_down/clear_i; slave drives the score outputs.
interface score_counter_if;
    logic       count_up;
    logic       count_down;
    logic       clear_i;
    logic [3:0] score_tens_o;
    logic [3:0] score_ones_o;
    logic       win_o;
    logic       change_o;

    modport master (
        output count_up,
        output count_down,
        output clear_i,
        input  score_tens_o,
        input  score_ones_o,
        input  win_o,
        input  change_o
    );

    modport slave (
        input  count_up,
        input  count_down,
        input  clear_i,
        output score_tens_o,
        output score_ones_o,
        output win_o,
        output change_o
    );
endinterface

// File: rtl/score_counter.sv
// score_counter: two-digit BCD score driven by rising edges of count_up/down.
// Ports: clk_1khz, rst_n (async low), bus (slave: events in, digits/win/change out).
module score_counter #(
    parameter int MAX_SCORE    = 99,
    parameter int WIN_SCORE    = 21,
    parameter int FLASH_CYCLES = 250
) (
    input  logic            clk_1khz,
    input  logic            rst_n,
    score_counter_if.slave  bus
);
    localparam logic [3:0] MAX_T = 4'(MAX_SCORE / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_SCORE % 10);
    localparam logic [3:0] WIN_T = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_O = 4'(WIN_SCORE % 10);
    localparam logic [9:0] FLASH_LOAD = 10'(FLASH_CYCLES - 1);

    typedef enum logic {
        IDLE,
        FLASH
    } state_t;

    logic       prev_up;
    logic       prev_down;
    logic       up_evt;
    logic       dn_evt;

    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic [3:0] tens_d;
    logic [3:0] ones_d;
    logic       win_q;
    logic       win_d;
    logic       changed;
    logic       at_max;
    logic       at_zero;

    state_t     state_q;
    state_t     state_d;
    logic [9:0] cnt_q;
    logic [9:0] cnt_d;

    assign up_evt  = bus.count_up & ~prev_up;
    assign dn_evt  = bus.count_down & ~prev_down;
    assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            prev_up   <= 1'b0;
            prev_down <= 1'b0;
        end else begin
            prev_up   <= bus.count_up;
            prev_down <= bus.count_down;
        end
    end

    // Priority: clear, then simultaneous events cancel, then up, then down.
    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        changed = 1'b0;
        if (bus.clear_i) begin
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            changed = !at_zero;
        end else if (up_evt && dn_evt) begin
            changed = 1'b0;
        end else if (up_evt) begin
            if (!at_max) begin
                changed = 1'b1;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end else if (dn_evt) begin
            if (!at_zero) begin
                changed = 1'b1;
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // Digit-wise compare avoids converting the BCD score to binary.
    always_comb begin
        win_d = (tens_d > WIN_T) || ((tens_d == WIN_T) && (ones_d >= WIN_O));
    end

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            win_q  <= 1'b0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
            win_q  <= win_d;
        end
    end

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A change in either state (re)loads the counter, so a retrigger
    // always yields a full-length strobe from the latest change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (changed) begin
            state_d = FLASH;
            cnt_d   = FLASH_LOAD;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = 10'd0;
                end
                FLASH: begin
                    if (cnt_q == 10'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 10'd0;
                end
            endcase
        end
    end

    assign bus.score_tens_o = tens_q;
    assign bus.score_ones_o = ones_q;
    assign bus.win_o        = win_q;
    assign bus.change_o     = (state_q == FLASH);
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed bench for score_counter with a result scoreboard.
// Expected digits/win are queued when an event is driven and popped on update.
module tb_score_counter;
    logic clk_1khz;
    logic rst_n;

    score_counter_if sif ();

    score_counter #(
        .MAX_SCORE    (99),
        .WIN_SCORE    (21),
        .FLASH_CYCLES (250)
    ) dut (
        .clk_1khz (clk_1khz),
        .rst_n    (rst_n),
        .bus      (sif)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic       w;
    } exp_t;

    exp_t sbq[$];
    int   model_s;
    int   tests;
    int   fails;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    function automatic void push_exp();
        exp_t e;
        e.t = 4'(model_s / 10);
        e.o = 4'(model_s % 10);
        e.w = (model_s >= 21);
        sbq.push_back(e);
    endfunction

    task automatic check_sb(input string tag);
        exp_t e;
        chk({tag, "_sbq"}, 16'(sbq.size()), 16'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_tens"}, 16'(sif.score_tens_o), 16'(e.t));
            chk({tag, "_ones"}, 16'(sif.score_ones_o), 16'(e.o));
            chk({tag, "_win"}, 16'(sif.win_o), 16'(e.w));
        end
    endtask

    task automatic up_step(input string tag);
        sif.count_up = 1'b1;
        if (model_s < 99) model_s++;
        push_exp();
        tick();
        check_sb(tag);
        sif.count_up = 1'b0;
        tick();
    endtask

    task automatic down_step(input string tag);
        sif.count_down = 1'b1;
        if (model_s > 0) model_s--;
        push_exp();
        tick();
        check_sb(tag);
        sif.count_down = 1'b0;
        tick();
    endtask

    task automatic clear_step(input string tag);
        sif.clear_i = 1'b1;
        model_s = 0;
        push_exp();
        tick();
        check_sb(tag);
        sif.clear_i = 1'b0;
    endtask

    task automatic measure_flash(output int n);
        n = 0;
        while (sif.change_o === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sif.change_o !== 1'b0 && n < 1000) begin
            n++;
            tick();
        end
        chk({tag, "_idle_timeout"}, 16'(sif.change_o), 16'd0);
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        model_s = 0;
        rst_n = 1'b0;
        sif.count_up = 1'b0;
        sif.count_down = 1'b0;
        sif.clear_i = 1'b0;

        // reset held while count_up toggles
        for (int i = 0; i < 6; i++) begin
            sif.count_up = ~sif.count_up;
            tick();
        end
        sif.count_up = 1'b0;
        tick();
        chk("rst_tens", 16'(sif.score_tens_o), 16'd0);
        chk("rst_ones", 16'(sif.score_ones_o), 16'd0);
        chk("rst_win", 16'(sif.win_o), 16'd0);
        chk("rst_change", 16'(sif.change_o), 16'd0);

        rst_n = 1'b1;
        tick();

        // first event and full strobe length
        sif.count_up = 1'b1;
        model_s = 1;
        push_exp();
        tick();
        check_sb("first_up");
        chk("first_change", 16'(sif.change_o), 16'd1);
        measure_flash(n);
        chk("first_flash_len", 16'(n), 16'd250);
        sif.count_up = 1'b0;
        tick();

        // carry and borrow
        clear_step("clr_carry");
        for (int i = 0; i < 10; i++) up_step("carry_up");
        chk("carry_tens", 16'(sif.score_tens_o), 16'd1);
        chk("carry_ones", 16'(sif.score_ones_o), 16'd0);
        down_step("borrow_dn");
        chk("borrow_tens", 16'(sif.score_tens_o), 16'd0);
        chk("borrow_ones", 16'(sif.score_ones_o), 16'd9);

        // win flag
        clear_step("clr_win");
        for (int i = 0; i < 20; i++) up_step("win_up");
        chk("win_at20", 16'(sif.win_o), 16'd0);
        up_step("win_21");
        chk("win_at21", 16'(sif.win_o), 16'd1);
        down_step("win_dn");
        chk("win_at20b", 16'(sif.win_o), 16'd0);

        // upper saturation
        for (int i = 0; i < 85; i++) up_step("sat_up");
        chk("sat_tens", 16'(sif.score_tens_o), 16'd9);
        chk("sat_ones", 16'(sif.score_ones_o), 16'd9);
        wait_idle("sat");
        for (int i = 0; i < 5; i++) begin
            up_step("sat_hold");
            chk("sat_no_flash", 16'(sif.change_o), 16'd0);
        end

        // lower saturation
        clear_step("clr_zero");
        chk("clr_change", 16'(sif.change_o), 16'd1);
        wait_idle("zero");
        down_step("zero_dn");
        chk("zero_no_flash", 16'(sif.change_o), 16'd0);

        // clear at zero does not flash
        clear_step("clr_at_zero");
        chk("clr_zero_no_flash", 16'(sif.change_o), 16'd0);

        // held level gives exactly one event
        sif.count_up = 1'b1;
        model_s = 1;
        push_exp();
        tick();
        check_sb("held_first");
        for (int i = 0; i < 2000; i++) tick();
        chk("held_tens", 16'(sif.score_tens_o), 16'd0);
        chk("held_ones", 16'(sif.score_ones_o), 16'd1);
        sif.count_up = 1'b0;
        tick();
        wait_idle("held");

        // simultaneous edges cancel
        sif.count_up = 1'b1;
        sif.count_down = 1'b1;
        push_exp();
        tick();
        check_sb("simul");
        chk("simul_no_flash", 16'(sif.change_o), 16'd0);
        sif.count_up = 1'b0;
        sif.count_down = 1'b0;
        tick();

        // clear then retrigger 100 cycles into the strobe
        for (int i = 0; i < 14; i++) up_step("to15");
        chk("at15_ones", 16'(sif.score_ones_o), 16'd5);
        wait_idle("pre_clr");
        clear_step("clr15");
        chk("clr15_change", 16'(sif.change_o), 16'd1);
        for (int i = 0; i < 99; i++) tick();
        sif.count_up = 1'b1;
        model_s = 1;
        push_exp();
        tick();
        check_sb("retrig_up");
        measure_flash(n);
        chk("retrig_flash_len", 16'(n), 16'd250);
        sif.count_up = 1'b0;
        tick();

        // asynchronous reset during a strobe
        up_step("pre_rst");
        tick();
        chk("pre_rst_change", 16'(sif.change_o), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_change", 16'(sif.change_o), 16'd0);
        chk("async_rst_ones", 16'(sif.score_ones_o), 16'd0);
        model_s = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_change", 16'(sif.change_o), 16'd0);
        chk("sb_drained", 16'(sbq.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Downstream consumer of the pushbutton processor stage.
- Takes its count_up (short press) and count_down (long press) event signals and maintains a two-digit BCD score, 00..MAX_SCORE.
- Outputs feed the 7-segment display multiplexer directly: separate tens/ones nibbles, a win flag, and a change-indication strobe.
- Runs entirely in the 1 kHz clock domain.

Parameters:
- MAX_SCORE, 99: upper saturation value, decimal, legal 1..99.
- WIN_SCORE, 21: score at which win_o asserts, decimal, legal 1..MAX_SCORE.
- FLASH_CYCLES, 250: length of the change_o strobe in clk_1khz cycles (250 ms), legal 1..1023.

Ports:
- clk_1khz, input, 1: system clock, 1 kHz.
- rst_n, input, 1: asynchronous active-low reset.
- count_up, input, 1: increment request from the pushbutton processor; rising-edge significant.
- count_down, input, 1: decrement request from the pushbutton processor; rising-edge significant.
- clear_i, input, 1: synchronous score clear, level, active-high.
- score_tens_o, output, 4: BCD tens digit.
- score_ones_o, output, 4: BCD ones digit.
- win_o, output, 1: high while score >= WIN_SCORE.
- change_o, output, 1: high for FLASH_CYCLES cycles after any score change.

Behaviour:
- Reset (rst_n low, asynchronous):
  - score_tens_o = 0, score_ones_o = 0, win_o = 0, change_o = 0.
  - Edge-detect history registers = 0.
  - Flash counter = 0.
  - Applies immediately and holds while rst_n is low; the first edge detection happens on the first clock after release.
- Edge detection:
  - count_up and count_down are each registered once (prev_*).
  - up_evt = count_up & ~prev_up; dn_evt = count_down & ~prev_down.
  - A level held for many cycles produces exactly one event.
- Score update, registered, 1-cycle latency: score outputs change on the clock edge after the edge that samples the rising input. Priority order:
  1. clear_i high: score = 00, regardless of events. change_o is retriggered only if the score was nonzero.
  2. up_evt and dn_evt in the same cycle: no change, no flash.
  3. up_evt: if score == MAX_SCORE, hold (saturate), no flash. Otherwise ones+1; if ones was 9, ones = 0 and tens+1.
  4. dn_evt: if score == 00, hold (saturate), no flash. Otherwise ones-1; if ones was 0, ones = 9 and tens-1.
- Arithmetic is pure BCD on 4-bit digits. Digits never hold values above 9. No binary-to-BCD conversion is used.
- win_o:
  - Registered compare of (tens*10 + ones) >= WIN_SCORE.
  - Updated in the same cycle as the score: it reflects the new score.
  - Deasserts when a decrement or clear drops the score below WIN_SCORE.
- change_o state machine:
  - States: IDLE, FLASH.
  - IDLE -> FLASH on any actual score change; the flash counter loads FLASH_CYCLES-1.
  - In FLASH, the counter decrements each cycle. At 0, return to IDLE.
  - A new change while in FLASH reloads the counter (retrigger). change_o = (state == FLASH).
  - change_o rises in the same cycle as the new score appears.
- Saturation attempts (up at MAX_SCORE, down at 00) leave all outputs and state unchanged.
- Reset mid-FLASH: counter and state are cleared immediately and change_o drops asynchronously.

Test Plan:
- Reset: hold rst_n=0, toggle count_up -> score 00, win_o=0, change_o=0. Release, then one count_up rising edge -> score 01 one cycle later, change_o high for exactly 250 cycles.
- Digit carry and borrow: 10 up events -> tens=1, ones=0. One down event -> tens=0, ones=9.
- Saturation: 99 up events, then 5 more -> score stays 99 with no change_o retrigger. From 00, one down event -> 00 and change_o stays low.
- Win flag: 21 up events -> win_o rises with score 21. One down event -> 20, win_o=0.
- Held level and simultaneous events: count_up held 2000 cycles -> exactly +1. Rising edges of count_up and count_down in the same cycle -> no change.
- Clear and retrigger: score 15 with clear_i pulsed 1 cycle -> 00 next cycle, change_o high. An up event 100 cycles into FLASH -> 01, and change_o stays high 250 cycles from the retrigger.
